// File: rtl/uart_tx_os_if.sv
// Byte-input handshake of the oversampled UART transmitter.
// Transfer rule: P_DATA moves on a rising clock edge where data_valid and ready are both 1;
// the source keeps data_valid and P_DATA stable until that edge, and ready does not wait for data_valid.
interface uart_tx_os_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  ready;

  modport master (output P_DATA, output data_valid, input ready);
  modport slave  (input P_DATA, input data_valid, output ready);
endinterface

// File: rtl/uart_tx_os.sv
// Oversampled UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// A one-entry holding register lets the next byte start right after the current stop bit.
module uart_tx_os #(
  parameter int DATA_WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  uart_tx_os_if.slave        bus,
  input  logic [5:0]         Prescale,
  input  logic               parity_enable,
  input  logic               parity_type,
  output logic               TX_OUT,
  output logic               busy,
  output logic [2:0]         state_dbg
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int            BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  logic [2:0]            state, state_n;
  logic [DATA_WIDTH-1:0] shift_reg, shift_n;
  logic [DATA_WIDTH-1:0] hold_reg, hold_reg_n;
  logic                  hold_full, hold_full_n;
  logic [BW-1:0]         bit_cnt, bit_cnt_n;
  logic [5:0]            presc_cnt, presc_cnt_n;
  logic [5:0]            presc_lat, presc_lat_n;
  logic                  par_en, par_en_n;
  logic                  par_bit, par_bit_n;
  logic                  tx_reg, tx_n;
  logic                  load;
  logic                  bit_done;
  logic [5:0]            presc_eff;

  assign presc_eff = (Prescale < 6'd4) ? 6'd4 : Prescale;
  assign bit_done  = (presc_cnt == presc_lat - 6'd1);

  assign bus.ready = ~hold_full;
  assign TX_OUT    = tx_reg;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_comb begin
    state_n     = state;
    shift_n     = shift_reg;
    hold_reg_n  = hold_reg;
    hold_full_n = hold_full;
    bit_cnt_n   = bit_cnt;
    presc_cnt_n = presc_cnt;
    presc_lat_n = presc_lat;
    par_en_n    = par_en;
    par_bit_n   = par_bit;
    load        = 1'b0;
    tx_n        = 1'b1;

    if (state != IDLE) presc_cnt_n = bit_done ? 6'd0 : presc_cnt + 6'd1;

    case (state)
      IDLE:   if (hold_full) load = 1'b1;
      START:  if (bit_done) begin
                state_n   = DATA;
                bit_cnt_n = '0;
              end
      DATA:   if (bit_done) begin
                shift_n = shift_reg >> 1;
                if (bit_cnt == LAST_BIT) state_n = par_en ? PARITY : STOP;
                else                     bit_cnt_n = bit_cnt + BW'(1);
              end
      PARITY: if (bit_done) state_n = STOP;
      STOP:   if (bit_done) begin
                if (hold_full) load = 1'b1;
                else           state_n = IDLE;
              end
      default: state_n = IDLE;
    endcase

    // Parity type is folded into the parity bit at load, so only the bit itself is kept.
    if (load) begin
      state_n     = START;
      shift_n     = hold_reg;
      hold_full_n = 1'b0;
      bit_cnt_n   = '0;
      presc_cnt_n = 6'd0;
      presc_lat_n = presc_eff;
      par_en_n    = parity_enable;
      par_bit_n   = (^hold_reg) ^ parity_type;
    end

    // Loads only happen with hold_full=1, so acceptance never collides with a load.
    if (bus.data_valid && !hold_full) begin
      hold_full_n = 1'b1;
      hold_reg_n  = bus.P_DATA;
    end

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_bit_n;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      shift_reg <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      presc_cnt <= 6'd0;
      presc_lat <= 6'd4;
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
      tx_reg    <= 1'b1;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      hold_reg  <= hold_reg_n;
      hold_full <= hold_full_n;
      bit_cnt   <= bit_cnt_n;
      presc_cnt <= presc_cnt_n;
      presc_lat <= presc_lat_n;
      par_en    <= par_en_n;
      par_bit   <= par_bit_n;
      tx_reg    <= tx_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_os.sv
// Bench for uart_tx_os: table-driven frame vectors, back-to-back, reset and random loopback
// through a line-decoding monitor that pops expected bytes from a queue.
module tb_uart_tx_os;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] prescale;
  logic       parity_enable;
  logic       parity_type;
  logic       tx_out;
  logic       busy;
  logic [2:0] state_dbg;

  uart_tx_os_if #(.DATA_WIDTH(W)) bus ();

  uart_tx_os #(.DATA_WIDTH(W)) dut (
    .CLK(clk), .RST(rst), .bus(bus), .Prescale(prescale),
    .parity_enable(parity_enable), .parity_type(parity_type),
    .TX_OUT(tx_out), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [5:0] presc;
    logic [5:0] mid_presc;
    bit         pe;
    bit         pt;
    int         exp_p;
    bit         exp_par;
    int         exp_len;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  int mon_p = 8;
  bit mon_pe = 1'b0;
  bit mon_pt = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Length of the most recent busy run, sampled on falling edges.
  int run_len = 0;
  int last_run = 0;
  always @(negedge clk) begin
    if (busy === 1'b1) run_len++;
    else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
  end

  // Line monitor: detects a start edge, samples each bit mid-slot, compares against exp_q.
  bit           prev_line = 1'b1;
  bit           m_abort;
  logic [W-1:0] m_data, m_exp;
  logic         m_start, m_par, m_stop;

  task automatic mon_wait(input int n);
    for (int i = 0; i < n; i++) begin
      if (m_abort) break;
      @(negedge clk);
      if (rst) m_abort = 1'b1;
    end
  endtask

  always begin
    @(negedge clk);
    if (!rst && prev_line && tx_out === 1'b0) begin
      m_abort = 1'b0;
      m_par   = 1'b0;
      mon_wait(mon_p / 2);
      m_start = tx_out;
      for (int i = 0; i < W; i++) begin
        mon_wait(mon_p);
        m_data[i] = tx_out;
      end
      if (mon_pe) begin
        mon_wait(mon_p);
        m_par = tx_out;
      end
      mon_wait(mon_p);
      m_stop = tx_out;
      if (!m_abort) begin
        check("rx_frame_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          m_exp = exp_q.pop_front();
          check("rx_start", m_start, 0);
          check("rx_data", m_data, m_exp);
          if (mon_pe) check("rx_parity", m_par, (^m_exp) ^ mon_pt);
          check("rx_stop", m_stop, 1);
        end
      end
    end
    prev_line = tx_out;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check("wait_idle_timeout", busy, 0);
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready !== 1'b1) begin
      check("send_ready_timeout", bus.ready, 1);
      return;
    end
    bus.P_DATA = d;
    bus.data_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(d);
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  function automatic logic model_bit(input vec_t v, input int j);
    int slot;
    slot = j / v.exp_p;
    if (slot == 0) return 1'b0;
    if (slot <= W) return v.data[slot-1];
    if (v.pe && slot == W + 1) return v.exp_par;
    return 1'b1;
  endfunction

  task automatic run_vector(input vec_t v, input string tag);
    int mism;
    wait_idle();
    prescale = v.presc;
    parity_enable = v.pe;
    parity_type = v.pt;
    mon_p = v.exp_p;
    mon_pe = v.pe;
    mon_pt = v.pt;
    send_byte(v.data);
    check({tag, "_accept_line"}, {29'd0, tx_out, busy, bus.ready}, 3'b100);
    mism = 0;
    for (int j = 0; j < v.exp_len; j++) begin
      @(negedge clk);
      if (j == 5) prescale = v.mid_presc;
      if (j == 0) begin
        check({tag, "_fall"}, tx_out, 0);
        check({tag, "_ready_back"}, bus.ready, 1);
      end
      if (tx_out !== model_bit(v, j) || busy !== 1'b1) mism++;
    end
    check({tag, "_wave_mismatches"}, mism, 0);
    wait_idle();
    @(negedge clk);
    check({tag, "_busy_len"}, last_run, v.exp_len);
  endtask

  vec_t vecs[9];
  vec_t pv;
  int   n_rdy;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 6'd8,  6'd8,  1'b1, 1'b0, 8,  1'b0, 88};
    vecs[1] = '{8'h01, 6'd16, 6'd16, 1'b1, 1'b1, 16, 1'b0, 176};
    vecs[2] = '{8'h00, 6'd16, 6'd16, 1'b1, 1'b1, 16, 1'b1, 176};
    vecs[3] = '{8'h3C, 6'd16, 6'd16, 1'b0, 1'b0, 16, 1'b0, 160};
    vecs[4] = '{8'hFF, 6'd2,  6'd32, 1'b0, 1'b0, 4,  1'b0, 40};
    vecs[5] = '{8'h80, 6'd0,  6'd0,  1'b1, 1'b0, 4,  1'b1, 44};
    vecs[6] = '{8'hC3, 6'd3,  6'd3,  1'b1, 1'b1, 4,  1'b1, 44};
    vecs[7] = '{8'h7E, 6'd63, 6'd63, 1'b0, 1'b0, 63, 1'b0, 630};
    vecs[8] = '{8'h2B, 6'd5,  6'd9,  1'b1, 1'b0, 5,  1'b0, 55};

    rst = 1'b1;
    bus.P_DATA = '0;
    bus.data_valid = 1'b0;
    prescale = 6'd8;
    parity_enable = 1'b0;
    parity_type = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx_out, 1);
    check("reset_busy", busy, 0);
    check("reset_ready", bus.ready, 1);
    check("reset_state", state_dbg, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) run_vector(vecs[i], $sformatf("v%0d", i));

    // Back-to-back frames at P=8 without parity.
    wait_idle();
    prescale = 6'd8; parity_enable = 1'b0; parity_type = 1'b0;
    mon_p = 8; mon_pe = 1'b0; mon_pt = 1'b0;
    send_byte(8'h55);
    send_byte(8'hAA);
    bus.P_DATA = 8'h33;
    bus.data_valid = 1'b1;
    n_rdy = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.ready !== 1'b0) n_rdy++;
    end
    bus.data_valid = 1'b0;
    check("b2b_third_blocked", n_rdy, 0);
    repeat (79 - 21) @(negedge clk);
    check("b2b_ready_low", bus.ready, 0);
    check("b2b_stop1", tx_out, 1);
    @(negedge clk);
    check("b2b_ready_back", bus.ready, 1);
    check("b2b_start2", tx_out, 0);
    check("b2b_busy_held", busy, 1);
    wait_idle();
    @(negedge clk);
    check("b2b_busy_len", last_run, 160);

    // Reset during data bit 3 with a second byte buffered.
    wait_idle();
    prescale = 6'd8; parity_enable = 1'b0; parity_type = 1'b0;
    mon_p = 8; mon_pe = 1'b0; mon_pt = 1'b0;
    send_byte(8'h96);
    send_byte(8'h3C);
    repeat (34) @(negedge clk);
    check("rst_pre_state", state_dbg, 2);
    check("rst_pre_ready", bus.ready, 0);
    rst = 1'b1;
    #1;
    check("rst_async_tx", tx_out, 1);
    check("rst_async_busy", busy, 0);
    check("rst_async_ready", bus.ready, 1);
    check("rst_async_state", state_dbg, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clk);
    check("rst_after_idle_tx", tx_out, 1);
    pv = '{8'h5A, 6'd8, 6'd8, 1'b1, 1'b0, 8, 1'b0, 88};
    run_vector(pv, "post_rst");

    // Random loopback stream through the monitor.
    wait_idle();
    prescale = 6'd5; parity_enable = 1'b1; parity_type = 1'b1;
    mon_p = 5; mon_pe = 1'b1; mon_pt = 1'b1;
    for (int i = 0; i < 256; i++) send_byte(8'($urandom_range(0, 255)));
    wait_idle();
    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("final_idle_tx", tx_out, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
